// File: rtl/regs_arb_pkg.sv
// Shared types for the register-bus arbiter.
// State encoding, default ack timeout, index-width helper.
package regs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Search starts one past the last grant and wraps.
module rr_arbiter
  import regs_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        gnt = '0;
        gnt[(int'(last) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/regs_bus_arbiter.sv
// Round-robin sequencer sharing one regs_if master port.
// One transaction in flight: issue, wait for ack or timeout, respond.
module regs_bus_arbiter
  import regs_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int IW         = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          write_en,
  output logic                          read_en,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [DATA_WIDTH-1:0]         read_data,
  input  logic                          data_ready,
  input  logic                          write_done,
  output logic                          busy,
  output logic [IW-1:0]                 grant_id
);

  arb_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rspv_q, rspv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic wen_q, wen_d;
  logic ren_q, ren_d;
  logic busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0] arb_idx;
  logic ack;
  logic [NUM_REQ-1:0] grant_oh;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .req (req_valid),
    .last(last_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // The opposite ack type never completes a transaction.
  assign ack = wr_q ? write_done : data_ready;
  assign grant_oh = NUM_REQ'(1) << grant_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = '0;
    rspv_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = ISSUE;
          last_d  = arb_idx;
          grant_d = arb_idx;
          wr_d    = req_write[arb_idx];
          addr_d  = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          ready_d = arb_gnt;
          wen_d   = req_write[arb_idx];
          ren_d   = ~req_write[arb_idx];
        end
      end
      ISSUE, WAIT: begin
        if (state_q == ISSUE) cnt_d = '0;
        if (ack) begin
          state_d = RESP;
          rspv_d  = grant_oh;
          rdata_d = wr_q ? '0 : read_data;
          err_d   = 1'b0;
        end else if (state_q == ISSUE) begin
          state_d = WAIT;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d = RESP;
          rspv_d  = grant_oh;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      rspv_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rspv_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign write_en   = wen_q;
  assign read_en    = ren_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Bench for regs_bus_arbiter: transaction-timeline model,
// directed scenarios plus randomized requesters and slave.
module tb_regs_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int T  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, write_data, read_data;
  logic rsp_err, write_en, read_en, data_ready, write_done, busy;
  logic [AW-1:0] addr;
  logic [IW-1:0] grant_id;

  always #5 clk = ~clk;

  regs_bus_arbiter #(
    .NUM_REQ(N), .DATA_DEPTH(16), .DATA_WIDTH(DW), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .write_en(write_en), .read_en(read_en),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .data_ready(data_ready),
    .write_done(write_done), .busy(busy), .grant_id(grant_id)
  );

  int nvec, nfail, cyc;
  // requester side
  bit pend[N];
  bit pw[N];
  logic [AW-1:0] pa[N];
  logic [DW-1:0] pd[N];
  bit gen_en;
  int gen_pct;
  bit refill[N];
  int cons_w, cons_c;
  // current transaction timeline: grant -> issue t_i -> response t_r
  bit act;
  int t_i, t_r, t_w, t_kind, t_d;
  bit t_wr, t_err;
  logic [AW-1:0] t_a;
  logic [DW-1:0] t_wd, t_rd, t_exp_rd;
  int last;
  // forced slave plan
  bit fp_en;
  int fp_kind, fp_d;
  logic [DW-1:0] fp_rd;
  // expected held outputs
  logic [IW-1:0] e_gid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  bit rst_now;
  // observations for literal checks
  int ready_cyc, rsp_cyc, ren_cnt, rsp_cnt;
  logic [DW-1:0] rsp_d;
  bit rsp_e;
  logic [N-1:0] rsp_vec;
  int grants[$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] e_rdy, e_rsp;
    bit e_wen, e_ren, e_busy, win, hit, nz1, nz2;
    int j;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && cons_w == i && cons_c == cyc - 1)
        pend[i] = 0;
      else if (pend[i] && !(act && t_w == i) && gen_en &&
               $urandom_range(0, 31) == 0)
        pend[i] = 0;
      if (!pend[i] && (refill[i] ||
          (gen_en && $urandom_range(0, 99) < gen_pct))) begin
        pend[i] = 1;
        pw[i] = 1'($urandom);
        pa[i] = AW'($urandom);
        pd[i] = DW'($urandom);
      end
      req_valid[i] = pend[i];
      req_write[i] = pw[i];
      req_addr[i*AW +: AW] = pa[i];
      req_wdata[i*DW +: DW] = pd[i];
    end
    rst = rst_now;
    win = act && cyc >= t_i && cyc < t_r;
    hit = win && t_kind == 0 && cyc == t_i + t_d;
    nz1 = ($urandom_range(0, 3) == 0);
    nz2 = ($urandom_range(0, 3) == 0);
    read_data = DW'($urandom);
    if (!win) begin
      data_ready = nz1;
      write_done = nz2;
    end else if (t_wr) begin
      write_done = hit;
      data_ready = (t_kind == 1) ? 1'b1 : nz1;
    end else begin
      data_ready = hit;
      write_done = (t_kind == 1) ? 1'b1 : nz2;
    end
    if (hit) read_data = t_rd;
    e_rdy = '0;
    e_rsp = '0;
    e_wen = 0;
    e_ren = 0;
    e_busy = act && cyc >= t_i && cyc <= t_r;
    if (act && cyc == t_i) begin
      e_gid = IW'(t_w);
      e_addr = t_a;
      e_wd = t_wd;
      cons_w = t_w;
      cons_c = cyc;
      e_rdy[t_w] = 1'b1;
      e_wen = t_wr;
      e_ren = !t_wr;
    end
    if (act && cyc == t_r) e_rsp[t_w] = 1'b1;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("write_en", 32'(write_en), 32'(e_wen));
    chk("read_en", 32'(read_en), 32'(e_ren));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("write_data", 32'(write_data), 32'(e_wd));
    if (act && cyc == t_r) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(t_exp_rd));
      chk("rsp_err", 32'(rsp_err), 32'(t_err));
    end
    if (|req_ready) begin
      ready_cyc = cyc;
      grants.push_back(int'(grant_id));
    end
    if (|rsp_valid) begin
      rsp_cyc = cyc;
      rsp_d = rsp_rdata;
      rsp_e = rsp_err;
      rsp_vec = rsp_valid;
      rsp_cnt++;
    end
    if (read_en) ren_cnt++;
    if (rst_now) begin
      act = 0;
      e_gid = '0;
      e_addr = '0;
      e_wd = '0;
      last = N - 1;
    end else if (act) begin
      if (cyc == t_r) act = 0;
    end else if (|req_valid) begin
      j = -1;
      for (int k = N; k >= 1; k--)
        if (req_valid[(last + k) % N]) j = (last + k) % N;
      t_w = j;
      last = j;
      t_wr = pw[j];
      t_a = pa[j];
      t_wd = pd[j];
      t_i = cyc + 1;
      if (fp_en) begin
        t_kind = fp_kind;
        t_d = fp_d;
        t_rd = fp_rd;
      end else begin
        j = $urandom_range(0, 9);
        t_kind = (j < 7) ? 0 : (j < 8) ? 1 : 2;
        t_d = ($urandom_range(0, 1) == 0) ?
              $urandom_range(0, 2) : $urandom_range(0, T + 2);
        t_rd = DW'($urandom);
      end
      if (t_kind == 0 && t_d <= T + 1) begin
        t_r = t_i + t_d + 1;
        t_err = 0;
        t_exp_rd = t_wr ? '0 : t_rd;
      end else begin
        t_r = t_i + T + 2;
        t_err = 1;
        t_exp_rd = '0;
      end
      act = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit model_busy();
    bit b;
    b = act;
    for (int i = 0; i < N; i++) b |= pend[i];
    return b;
  endfunction

  task automatic drain(int bound);
    for (int k = 0; k < bound && model_busy(); k++) step();
    chk("drain_done", 32'(model_busy()), 0);
  endtask

  task automatic one_req(int r, bit w, int a, int d,
                         int kind, int dly, int rdv);
    pend[r] = 1;
    pw[r] = w;
    pa[r] = AW'(a);
    pd[r] = DW'(d);
    fp_en = 1;
    fp_kind = kind;
    fp_d = dly;
    fp_rd = DW'(rdv);
    ready_cyc = -100;
    rsp_cyc = 0;
    rsp_d = 8'h5A;
    rsp_e = ~rsp_e;
    rsp_vec = '0;
    ren_cnt = 0;
    drain(40);
  endtask

  initial begin
    nvec = 0; nfail = 0; cyc = 0;
    gen_en = 0; gen_pct = 0; fp_en = 0;
    act = 0; last = N - 1; cons_w = -1; cons_c = -10;
    t_i = 0; t_r = 0; t_w = 0; t_kind = 0; t_d = 0;
    e_gid = '0; e_addr = '0; e_wd = '0; rst_now = 0;
    rsp_cnt = 0; rsp_e = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0;
      refill[i] = 0;
    end
    rst = 1; req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0;
    read_data = '0; data_ready = 0; write_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant_id", 32'(grant_id), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset_enables", 32'({write_en, read_en}), 0);

    one_req(0, 0, 3, 0, 0, 2, 8'hA5);
    chk("read_rdata", 32'(rsp_d), 32'h A5);
    chk("read_err", 32'(rsp_e), 0);
    chk("read_latency", 32'(rsp_cyc - ready_cyc), 3);
    chk("read_en_pulses", 32'(ren_cnt), 1);
    chk("read_rsp_vec", 32'(rsp_vec), 32'b001);

    one_req(1, 1, 15, 8'h3C, 0, 0, 8'hFF);
    chk("write_rdata", 32'(rsp_d), 0);
    chk("write_err", 32'(rsp_e), 0);
    chk("write_latency", 32'(rsp_cyc - ready_cyc), 1);
    chk("write_rsp_vec", 32'(rsp_vec), 32'b010);

    one_req(0, 0, 7, 0, 2, 0, 8'h11);
    chk("timeout_err", 32'(rsp_e), 1);
    chk("timeout_rdata", 32'(rsp_d), 0);
    chk("timeout_latency", 32'(rsp_cyc - ready_cyc), 6);

    one_req(2, 0, 9, 0, 0, 1, 8'h42);
    chk("after_to_rdata", 32'(rsp_d), 32'h42);
    chk("after_to_err", 32'(rsp_e), 0);
    chk("after_to_latency", 32'(rsp_cyc - ready_cyc), 2);

    one_req(0, 0, 5, 0, 1, 0, 8'h77);
    chk("wrong_ack_err", 32'(rsp_e), 1);
    chk("wrong_ack_latency", 32'(rsp_cyc - ready_cyc), 6);

    // reset while waiting for an ack that never comes
    pend[0] = 1; pw[0] = 0; pa[0] = 4'd2;
    fp_kind = 2;
    for (int k = 0; k < 20 && !(act && cyc == t_i + 2); k++)
      step();
    rsp_cnt = 0;
    rst_now = 1;
    step();
    rst_now = 0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_grant_id", 32'(grant_id), 0);
    chk("midrst_addr", 32'(addr), 0);
    repeat (8) step();
    chk("midrst_no_rsp", 32'(rsp_cnt), 0);

    fp_kind = 0; fp_d = 0;
    refill[0] = 1; refill[1] = 1;
    grants.delete();
    for (int k = 0; k < 40 && grants.size() < 4; k++) step();
    refill[0] = 0; refill[1] = 0;
    chk("fair_count", 32'(grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      chk("fair_g0", 32'(grants[0]), 0);
      chk("fair_g1", 32'(grants[1]), 1);
      chk("fair_g2", 32'(grants[2]), 0);
      chk("fair_g3", 32'(grants[3]), 1);
    end
    drain(40);

    fp_en = 0;
    gen_en = 1;
    gen_pct = 20;
    for (int k = 0; k < 4000; k++) begin
      rst_now = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_now = 0;
    gen_en = 0;
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
